// File: rtl/new_means_sequencer.sv
// Centroid-update sequencer for the new-means block.
// Steps every centroid through divide, compare and write-back.
module new_means_sequencer #(
  parameter int          centroid_num    = 8,
  parameter int          cordinate_width = 13,
  parameter int          dataWidth       = 91,
  parameter int          addrWidth       = 8,
  parameter int          cent_base_addr  = 0,
  parameter int          div_latency     = 2,
  parameter int unsigned move_thresh     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [7:0]           empty_mask,
  output logic [2:0]           cent_cnt,
  output logic                 divider_en,
  input  logic                 divide_by_0,
  input  logic [dataWidth-1:0] new_centroid,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [addrWidth-1:0] mem_addr,
  output logic [dataWidth-1:0] mem_wdata,
  input  logic [dataWidth-1:0] mem_rdata
);

  localparam int NCoord = 7;
  localparam int CntW = (div_latency > 1) ? $clog2(div_latency) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(div_latency - 1);
  localparam logic [2:0] LastCent = 3'(centroid_num - 1);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    CMP,
    WRITE,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           cent_q, cent_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 conv_q, conv_d;
  logic [7:0]           empty_q, empty_d;
  logic                 moved_q, moved_d;
  logic                 div_en_q, div_en_d;
  logic                 re_q, re_d;
  logic                 we_q, we_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic [dataWidth-1:0] wdata_q, wdata_d;
  logic [dataWidth-1:0] newc_q, newc_d;
  logic                 dz_q, dz_d;

  // Widen by one bit so the signed difference can never overflow.
  function automatic logic moved_f(
    input logic [dataWidth-1:0] a,
    input logic [dataWidth-1:0] b
  );
    logic signed [cordinate_width:0] x;
    logic signed [cordinate_width:0] y;
    logic signed [cordinate_width:0] d;
    logic [cordinate_width:0]        m;
    logic                            r;
    r = 1'b0;
    for (int i = 0; i < NCoord; i++) begin
      x = {a[i*cordinate_width+cordinate_width-1],
           a[i*cordinate_width +: cordinate_width]};
      y = {b[i*cordinate_width+cordinate_width-1],
           b[i*cordinate_width +: cordinate_width]};
      d = x - y;
      m = d[cordinate_width] ? $unsigned(-d) : $unsigned(d);
      if (32'(m) > move_thresh) r = 1'b1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cent_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      conv_q   <= 1'b0;
      empty_q  <= '0;
      moved_q  <= 1'b0;
      div_en_q <= 1'b0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      newc_q   <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cent_q   <= cent_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      conv_q   <= conv_d;
      empty_q  <= empty_d;
      moved_q  <= moved_d;
      div_en_q <= div_en_d;
      re_q     <= re_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      newc_q   <= newc_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cent_d   = cent_q;
    conv_d   = conv_q;
    empty_d  = empty_q;
    moved_d  = moved_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    newc_d   = newc_q;
    dz_d     = dz_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    div_en_d = 1'b0;
    re_d     = 1'b0;
    we_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          cent_d  = '0;
          empty_d = '0;
          moved_d = 1'b0;
          conv_d  = 1'b0;
        end
      end
      CALC: begin
        if (cnt_q == LastCnt) begin
          newc_d  = new_centroid;
          dz_d    = divide_by_0;
          state_d = CMP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      CMP: begin
        if (!dz_q && moved_f(newc_q, mem_rdata)) moved_d = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        if (dz_q) empty_d[cent_q] = 1'b1;
        if (cent_q == LastCent) begin
          state_d = DONE;
          conv_d  = !moved_q;
        end else begin
          cent_d  = cent_q + 3'd1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state, so they are Moore.
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    div_en_d = (state_d == CALC);
    re_d     = (state_d == CALC) && (cnt_d == LastCnt);
    we_d     = (state_d == WRITE) && !dz_d;
    if (re_d || we_d) begin
      addr_d = addrWidth'(cent_base_addr) + addrWidth'(cent_d);
    end
    if (we_d) wdata_d = newc_q;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign empty_mask = empty_q;
  assign cent_cnt   = cent_q;
  assign divider_en = div_en_q;
  assign mem_re     = re_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_new_means_sequencer.sv
// Bench for new_means_sequencer: directed table, random passes,
// reset mid-pass, against a memory model and a pass-level reference.
module tb_new_means_sequencer;
  localparam int DW = 91;
  localparam int AW = 8;
  localparam int CW = 13;
  localparam int DL = 2;
  localparam int P  = DL + 2;
  localparam int MT = 2;
  localparam int PASS_CYC = 8 * P + 1;

  logic          clk, rst_n, start;
  logic          busy, done, converged;
  logic [7:0]    empty_mask;
  logic [2:0]    cent_cnt;
  logic          divider_en, divide_by_0;
  logic [DW-1:0] new_centroid;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] nc_tab [8];
  logic [7:0]    dz_tab;
  logic [DW-1:0] mem [256];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  int n_chk, n_fail;
  logic [AW-1:0] wa [$];
  logic [DW-1:0] wd [$];
  logic [DW-1:0] exp_mem [8];
  logic          exp_conv_m;
  logic [7:0]    exp_empty_m;
  int            exp_wk [$];

  typedef struct {
    int         mode;
    logic [7:0] dz;
    int         glitch;
    logic       exp_conv;
    logic [7:0] exp_empty;
  } vec_t;
  vec_t tab [7];

  new_means_sequencer #(.move_thresh(MT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .converged(converged),
    .empty_mask(empty_mask), .cent_cnt(cent_cnt),
    .divider_en(divider_en), .divide_by_0(divide_by_0),
    .new_centroid(new_centroid), .mem_re(mem_re),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign new_centroid = nc_tab[cent_cnt];
  assign divide_by_0  = dz_tab[cent_cnt];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (ld_en) mem[ld_addr] <= ld_data;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    logic [CW-1:0] c;
    c = CW'(k + 1);
    return {7{c}};
  endfunction

  function automatic logic [DW-1:0] set_c(input logic [DW-1:0] v,
                                          input int i,
                                          input logic [CW-1:0] c);
    logic [DW-1:0] r;
    r = v;
    r[i*CW +: CW] = c;
    return r;
  endfunction

  function automatic logic [127:0] outs();
    return {busy, done, converged, divider_en, mem_re, mem_we,
            cent_cnt, empty_mask, mem_addr};
  endfunction

  task automatic preload(input int k, input logic [DW-1:0] d);
    ld_en = 1'b1;
    ld_addr = AW'(k);
    ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Pass-level reference: plain integer arithmetic per coordinate.
  task automatic model_pass();
    bit mv;
    int o, n, d;
    mv = 1'b0;
    exp_empty_m = '0;
    exp_wk.delete();
    for (int k = 0; k < 8; k++) begin
      exp_mem[k] = mem[k];
      if (dz_tab[k]) begin
        exp_empty_m[k] = 1'b1;
      end else begin
        exp_wk.push_back(k);
        for (int i = 0; i < 7; i++) begin
          o = int'($signed(mem[k][i*CW +: CW]));
          n = int'($signed(nc_tab[k][i*CW +: CW]));
          d = n - o;
          if (d < 0) d = -d;
          if (d > MT) mv = 1'b1;
        end
        exp_mem[k] = nc_tab[k];
      end
    end
    exp_conv_m = !mv;
  endtask

  task automatic run_pass(input int glitch, output int done_cyc,
                          output int ndone, output bit busy_bad,
                          output bit sched_bad, output bit ovl);
    int k, ph;
    done_cyc = -1;
    ndone = 0;
    busy_bad = 1'b0;
    sched_bad = 1'b0;
    ovl = 1'b0;
    wa.delete();
    wd.delete();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= PASS_CYC + 2; c++) begin
      if (busy !== (c <= PASS_CYC)) busy_bad = 1'b1;
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (mem_re && mem_we) ovl = 1'b1;
      if (mem_we === 1'b1) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
      end
      if (c <= 8 * P) begin
        k = (c - 1) / P;
        ph = (c - 1) % P;
        if (cent_cnt !== 3'(k)) sched_bad = 1'b1;
        if (divider_en !== (ph < DL)) sched_bad = 1'b1;
        if (mem_re !== (ph == DL - 1)) sched_bad = 1'b1;
        if (mem_we !== (ph == P - 1 && !dz_tab[k])) sched_bad = 1'b1;
      end
      start = (c == glitch);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic run_and_check(input string nm, input int glitch,
                               input bit use_exp, input logic ec,
                               input logic [7:0] ee);
    int dc, nd;
    bit bb, sb, ov, wok, mok;
    model_pass();
    run_pass(glitch, dc, nd, bb, sb, ov);
    chk({nm, "_done_cycle"}, dc, PASS_CYC);
    chk({nm, "_done_pulses"}, nd, 1);
    chk({nm, "_busy_window"}, bb, 0);
    chk({nm, "_schedule"}, sb, 0);
    chk({nm, "_re_we_overlap"}, ov, 0);
    chk({nm, "_write_count"}, wa.size(), exp_wk.size());
    wok = (wa.size() == exp_wk.size());
    if (wok) begin
      for (int i = 0; i < wa.size(); i++) begin
        if (wa[i] !== AW'(exp_wk[i]) || wd[i] !== nc_tab[exp_wk[i]])
          wok = 1'b0;
      end
    end
    chk({nm, "_write_log"}, wok, 1);
    mok = 1'b1;
    for (int k = 0; k < 8; k++) if (mem[k] !== exp_mem[k]) mok = 1'b0;
    chk({nm, "_memory"}, mok, 1);
    chk({nm, "_empty_mask"}, empty_mask, exp_empty_m);
    chk({nm, "_converged"}, converged, exp_conv_m);
    if (use_exp) begin
      chk({nm, "_tab_converged"}, converged, ec);
      chk({nm, "_tab_empty"}, empty_mask, ee);
    end
  endtask

  task automatic apply_mode(input vec_t v);
    dz_tab = v.dz;
    for (int k = 0; k < 8; k++) nc_tab[k] = pat(k);
    unique case (v.mode)
      0: for (int k = 0; k < 8; k++) preload(k, '0);
      1: ;
      2, 3: begin
        for (int k = 0; k < 8; k++) preload(k, pat(k));
        preload(3, set_c(pat(3), 4, 13'h1FFF));
        nc_tab[3] = set_c(pat(3), 4, (v.mode == 2) ? 13'h0001 : 13'h0002);
      end
      4: begin
        for (int k = 0; k < 8; k++) preload(k, pat(k));
        nc_tab[2] = {7{13'h0AAA}};
        nc_tab[5] = {7{13'h0AAA}};
      end
      default: begin
        for (int k = 0; k < 8; k++)
          nc_tab[k] = DW'({$urandom, $urandom, $urandom});
      end
    endcase
  endtask

  initial begin
    logic [DW-1:0] old, nv;
    logic [CW-1:0] c;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    dz_tab = '0;
    for (int k = 0; k < 8; k++) nc_tab[k] = '0;
    tab[0] = '{0, 8'h00, -1, 1'b0, 8'h00};
    tab[1] = '{1, 8'h00, -1, 1'b1, 8'h00};
    tab[2] = '{2, 8'h00, -1, 1'b1, 8'h00};
    tab[3] = '{3, 8'h00, -1, 1'b0, 8'h00};
    tab[4] = '{4, 8'h24, -1, 1'b1, 8'h24};
    tab[5] = '{1, 8'h00, 13, 1'b1, 8'h00};
    tab[6] = '{5, 8'hFF, -1, 1'b1, 8'hFF};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), '0);
    chk("reset_wdata", mem_wdata, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 7; t++) begin
      apply_mode(tab[t]);
      run_and_check($sformatf("vec%0d", t), tab[t].glitch, 1'b1,
                    tab[t].exp_conv, tab[t].exp_empty);
    end

    for (int r = 0; r < 6; r++) begin
      dz_tab = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      for (int k = 0; k < 8; k++) begin
        old = DW'({$urandom, $urandom, $urandom});
        preload(k, old);
        nv = old;
        if ($urandom_range(0, 1) == 0) begin
          for (int i = 0; i < 7; i++) begin
            if ($urandom_range(0, 5) == 0) begin
              c = old[i*CW +: CW] + CW'($urandom_range(0, 8)) - 13'd4;
              nv = set_c(nv, i, c);
            end
          end
        end
        nc_tab[k] = nv;
      end
      run_and_check($sformatf("rnd%0d", r), -1, 1'b0, 1'b0, 8'h00);
    end

    dz_tab = '0;
    for (int k = 0; k < 8; k++) begin
      preload(k, '0);
      nc_tab[k] = pat(k);
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("rst_pre_write", {mem_we, mem_addr}, {1'b1, 8'd4});
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", outs(), '0);
    chk("rst_async_wdata", mem_wdata, '0);
    @(posedge clk);
    #1;
    chk("rst_mem4_kept", mem[4], '0);
    chk("rst_mem3_written", mem[3], pat(3));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_and_check("rst_fresh", -1, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/new_means_sequencer.md
# new_means_sequencer

Controller that drives the `new_means_calculation_block` through one full centroid-update pass. On `start` it steps `cent_cnt` over all centroids and holds `divider_en` for the divider latency. For each centroid it:
- captures `new_centroid` and `divide_by_0`;
- reads the previous centroid from centroid memory and compares the two;
- writes the new centroid back unless the divide was by zero.

At the end it reports convergence and the mask of empty clusters to the top-level K-means controller.

## Interface
Parameters:
- `centroid_num`, 8, number of centroids, fixed at 8 by the 3-bit `cent_cnt`.
- `cordinate_width`, 13, width of one signed coordinate.
- `dataWidth`, 91, packed centroid width, 7 × `cordinate_width`; coordinate 0 sits at the LSBs.
- `addrWidth`, 8, centroid memory address width.
- `cent_base_addr`, 0, memory address of centroid 0; centroid k is stored at `cent_base_addr`+k.
- `div_latency`, 2, number of cycles `divider_en` must be held before `new_centroid`/`divide_by_0` are valid; must be ≥1.
- `move_thresh`, 0, unsigned; a coordinate counts as moved when |new−old| > `move_thresh`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a pass; ignored while `busy`.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse when the pass completes.
- `converged`  out  1  no non-empty centroid moved in the last pass; valid from `done` until the next `start`.
- `empty_mask`  out  8  bit k set when centroid k had `divide_by_0` in the last pass.
- `cent_cnt`  out  3  centroid select to the means block.
- `divider_en`  out  1  divider enable to the means block.
- `divide_by_0`  in  1  from the means block; the cluster count is zero.
- `new_centroid`  in  `dataWidth`  quotient result from the means block.
- `mem_re`  out  1  centroid memory read strobe; read data returns one cycle later.
- `mem_we`  out  1  centroid memory write strobe.
- `mem_addr`  out  `addrWidth`  shared read/write address.
- `mem_wdata`  out  `dataWidth`  write data.
- `mem_rdata`  in  `dataWidth`  read data, valid the cycle after `mem_re`.

## Operation
- FSM states: IDLE, CALC, CMP, WRITE, DONE.
- IDLE
  - On `start`: k←0, `empty_mask`←0, moved flag←0, wait counter←0, go to CALC.
- CALC
  - Drives `cent_cnt`=k and `divider_en`=1; the wait counter increments every cycle.
  - On the cycle the counter reaches `div_latency`−1:
    - register `new_centroid` and `divide_by_0`;
    - pulse `mem_re` with `mem_addr`=`cent_base_addr`+k;
    - go to CMP.
- CMP
  - `divider_en`=0; `mem_rdata` holds the old centroid.
  - For each of the 7 coordinates, sign-extend both values to `cordinate_width`+1 bits, subtract, and take the absolute value.
  - If any result exceeds `move_thresh` and the divide was not by zero, set the moved flag.
  - Go to WRITE.
- WRITE
  - Divide not by zero: `mem_we`=1, `mem_addr`=`cent_base_addr`+k, `mem_wdata`=captured centroid.
  - Divide by zero: no write (the old centroid is kept) and `empty_mask`[k]←1.
  - If k=`centroid_num`−1 go to DONE; otherwise k←k+1, counter←0, go to CALC.
- DONE
  - `done`=1 and `converged`←!moved; go to IDLE.
- Empty clusters never count as moved. If all 8 clusters are empty, `converged`=1 and `empty_mask`=8'hFF.
- `start` is ignored in every state other than IDLE; a `start` asserted in the DONE cycle is dropped.
- Asserting `rst_n` low in any state:
  - forces IDLE and clears all registers;
  - no partial write completes after reset is asserted;
  - memory contents already written stay as they are.

## Timing
- Reset values: `busy`, `done`, `converged`, `divider_en`, `mem_re`, `mem_we` = 0; `cent_cnt`=0; `mem_addr`=0; `mem_wdata`=0; `empty_mask`=0.
- All outputs are registered (Moore outputs).
- Each centroid takes `div_latency`+2 cycles.
- With `start` sampled at cycle 0 and defaults:
  - centroid k occupies CALC in cycles 4k+1 and 4k+2, CMP in 4k+3, WRITE in 4k+4;
  - `done` is high in cycle 33;
  - `busy` is high from cycle 1 to cycle 33;
  - in general `done` arrives 8·(`div_latency`+2)+1 cycles after `start`.
- `cent_cnt` holds its value from the first CALC cycle of centroid k through its WRITE cycle.
- `mem_re` and `mem_we` are never high in the same cycle.

## Test plan
- Single pass:
  - stimulus: means block returns centroid k = {7{13'd(k+1)}} with no zero divides; memory is preloaded with zeros.
  - response: exactly 8 writes, to addresses 0..7, with the matching data; `empty_mask`=0; `converged`=0; `done` at cycle 33.
- Converged pass:
  - stimulus: memory already holds the same centroids the block returns.
  - response: 8 writes; `converged`=1.
- Threshold (`move_thresh`=2):
  - stimulus: one coordinate changes from 13'h1FFF (−1) to 13'h0001.
  - response: the diff is 2, so `converged`=1. Changing the new value to 13'h0002 (diff 3) gives `converged`=0.
- Empty clusters:
  - stimulus: `divide_by_0`=1 for centroids 2 and 5.
  - response:
    - no `mem_we` to addresses 2 and 5;
    - `empty_mask`=8'b0010_0100;
    - those two centroids' old data is unchanged;
    - `converged` depends only on the other six centroids.
- Handshake:
  - stimulus: `start` pulsed during CALC of centroid 3.
  - response: ignored; the pass finishes normally with one `done` pulse.
- Reset mid-pass:
  - stimulus: `rst_n` low during WRITE of centroid 4.
  - response: all outputs return to their reset values immediately; a fresh `start` then runs a full 33-cycle pass.
